// File: rtl/nds_stall_drain_ctrl_pkg.sv
// nds_stall_drain_ctrl_pkg: shared FSM state type and default parameters for the stall/drain controller
package nds_stall_drain_ctrl_pkg;
  localparam int CNT_W_DEF = 4;
  localparam int TMO_CYC_DEF = 64;
  localparam int GAP_CYC_DEF = 2;
  typedef enum logic [1:0] {IDLE, DRAIN, COOL} nds_state_e;
endpackage

// File: rtl/nds_flag_setclr.sv
// nds_flag_setclr: set/clear flag flop; ports clk, reset_n (async low), en (update enable when USE_EN_PIN), set, clr, q (flag)
module nds_flag_setclr #(
  parameter bit SET_OVER_CLR = 1'b0,
  parameter bit RESET_VALUE = 1'b0,
  parameter bit USE_EN_PIN = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic set,
  input  logic clr,
  output logic q
);
  logic upd;
  assign upd = USE_EN_PIN ? en : 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= RESET_VALUE;
    else if (upd) q <= SET_OVER_CLR ? (set | (q & ~clr)) : (~clr & (set | q));
endmodule

// File: rtl/nds_stall_drain_ctrl.sv
// nds_stall_drain_ctrl: outstanding counter + replay stall/drain FSM; in issue/retire/replay/flush/sb_empty, out issue_ready/stall_set/stall_clr/stall/out_cnt/replay_drop/tmo_err
module nds_stall_drain_ctrl
  import nds_stall_drain_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic             retire_valid,
  input  logic             replay_req,
  input  logic             flush,
  input  logic             sb_empty,
  output logic             issue_ready,
  output logic             stall_set,
  output logic             stall_clr,
  output logic             stall,
  output logic [CNT_W-1:0] out_cnt,
  output logic             replay_drop,
  output logic             tmo_err
);
  localparam int TW = $clog2(TMO_CYC);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  nds_state_e st;
  logic [CNT_W-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [GW-1:0] cool;
  logic full, empty, drained, tmo_hit;
  assign full = cnt == MAX;
  assign empty = cnt == '0;
  assign drained = empty & sb_empty;
  assign tmo_hit = tmo == TW'(TMO_CYC - 1);
  assign issue_ready = ~full;
  assign out_cnt = cnt;
  assign stall_set = reset_n & ~flush & (st == IDLE) & replay_req & ~drained;
  assign tmo_err = reset_n & ~flush & (st == DRAIN) & ~drained & tmo_hit;
  assign stall_clr = reset_n & (flush ? stall : (st == DRAIN) & (drained | tmo_hit));
  assign replay_drop = reset_n & ~flush & (st == COOL) & replay_req;
  nds_flag_setclr #(
    .SET_OVER_CLR(1'b0),
    .RESET_VALUE(1'b0),
    .USE_EN_PIN(1'b0)
  ) u_stall (
    .clk(clk),
    .reset_n(reset_n),
    .en(1'b1),
    .set(stall_set),
    .clr(stall_clr),
    .q(stall)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st <= IDLE;
      cnt <= '0;
      tmo <= '0;
      cool <= '0;
    end else if (flush) begin
      st <= IDLE;
      cnt <= '0;
      tmo <= '0;
      cool <= '0;
    end else begin
      cnt <= (issue_valid & ~retire_valid & ~full) ? cnt + CNT_W'(1) :
             (retire_valid & ~issue_valid & ~empty) ? cnt - CNT_W'(1) : cnt;
      if (st == IDLE && stall_set) begin
        st <= DRAIN;
        tmo <= '0;
      end else if (st == DRAIN) begin
        if (stall_clr) begin
          st <= COOL;
          cool <= '0;
        end else tmo <= tmo + TW'(1);
      end else if (st == COOL) begin
        if (cool == GW'(GAP_CYC - 1)) st <= IDLE;
        else cool <= cool + GW'(1);
      end
    end
endmodule

// File: tb/tb_nds_stall_drain_ctrl.sv
// tb_nds_stall_drain_ctrl: directed + random bench with a behavioural reference model
module tb_nds_stall_drain_ctrl;
  localparam int MAXC = 15;
  localparam int TMO = 64;
  localparam int GAP = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic issue_valid = 1'b0, retire_valid = 1'b0, replay_req = 1'b0, flush = 1'b0, sb_empty = 1'b1;
  logic issue_ready, stall_set, stall_clr, stall, replay_drop, tmo_err;
  logic [3:0] out_cnt;
  int total = 0;
  int bad = 0;
  int m_cnt, m_age, m_cool;
  bit m_drain, m_stall;
  nds_stall_drain_ctrl dut (
    .clk(clk),
    .reset_n(reset_n),
    .issue_valid(issue_valid),
    .retire_valid(retire_valid),
    .replay_req(replay_req),
    .flush(flush),
    .sb_empty(sb_empty),
    .issue_ready(issue_ready),
    .stall_set(stall_set),
    .stall_clr(stall_clr),
    .stall(stall),
    .out_cnt(out_cnt),
    .replay_drop(replay_drop),
    .tmo_err(tmo_err)
  );
  always #5 clk = ~clk;
  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, obs, exp);
    end
  endtask
  task automatic chkn(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input bit i, input bit r, input bit p, input bit f, input bit s);
    bit full, drained, e_set, e_clr, e_drop, e_tmo;
    issue_valid = i;
    retire_valid = r;
    replay_req = p;
    flush = f;
    sb_empty = s;
    #1;
    full = m_cnt == MAXC;
    drained = m_cnt == 0 && s;
    e_set = 0;
    e_clr = 0;
    e_drop = 0;
    e_tmo = 0;
    if (f) e_clr = m_stall;
    else if (m_cool > 0) e_drop = p;
    else if (m_drain) begin
      e_clr = drained || m_age == TMO - 1;
      e_tmo = !drained && m_age == TMO - 1;
    end else e_set = p && !drained;
    chk1("issue_ready", issue_ready, !full);
    chk1("stall_set", stall_set, e_set);
    chk1("stall_clr", stall_clr, e_clr);
    chk1("replay_drop", replay_drop, e_drop);
    chk1("tmo_err", tmo_err, e_tmo);
    chk1("stall", stall, m_stall);
    chkn("out_cnt", out_cnt, 4'(m_cnt));
    @(posedge clk);
    if (e_clr) m_stall = 0;
    else if (e_set) m_stall = 1;
    if (f) begin
      m_cnt = 0;
      m_drain = 0;
      m_cool = 0;
      m_age = 0;
    end else begin
      if (i && !r && !full) m_cnt++;
      else if (r && !i && m_cnt > 0) m_cnt--;
      if (m_cool > 0) m_cool--;
      else if (m_drain) begin
        if (e_clr) begin
          m_drain = 0;
          m_cool = GAP;
        end else m_age++;
      end else if (e_set) begin
        m_drain = 1;
        m_age = 0;
      end
    end
    @(negedge clk);
  endtask
  task automatic hit_reset();
    issue_valid = 1;
    replay_req = 1;
    sb_empty = 0;
    reset_n = 0;
    #1;
    chk1("rst_issue_ready", issue_ready, 1'b1);
    chk1("rst_stall", stall, 1'b0);
    chkn("rst_out_cnt", out_cnt, 4'd0);
    chk1("rst_stall_set", stall_set, 1'b0);
    chk1("rst_stall_clr", stall_clr, 1'b0);
    chk1("rst_replay_drop", replay_drop, 1'b0);
    chk1("rst_tmo_err", tmo_err, 1'b0);
    m_cnt = 0;
    m_age = 0;
    m_cool = 0;
    m_drain = 0;
    m_stall = 0;
    issue_valid = 0;
    replay_req = 0;
    sb_empty = 1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask
  initial begin
    hit_reset();
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 1, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    repeat (16) step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    repeat (14) step(0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    repeat (TMO) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    repeat (600) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    repeat (400) step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0);
    step(0, 0, 0, 1, 1);
    repeat (5) step(1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    hit_reset();
    repeat (3) step(0, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nds_stall_drain_ctrl.md
NDS_STALL_DRAIN_CTRL -- requirements
Module: nds_stall_drain_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 4, outstanding-counter width (max count 2^CNT_W-1).
REQ-002 SHALL have parameter TMO_CYC, default 64, drain timeout in cycles (>=2).
REQ-003 SHALL have parameter GAP_CYC, default 2, cooldown cycles after release (>=1).
REQ-004 SHALL have ports:
  clk  in  1  clock
  reset_n  in  1  asynchronous, active-low reset
  issue_valid  in  1  one request issued this cycle
  retire_valid  in  1  one request retired this cycle
  replay_req  in  1  replay requested; start stall/drain
  flush  in  1  pipeline flush
  sb_empty  in  1  store buffer empty
  issue_ready  out  1  ~full
  stall_set  out  1  set pulse to stall flag
  stall_clr  out  1  clr pulse to stall flag
  stall  out  1  registered stall flag
  out_cnt  out  CNT_W  outstanding count
  replay_drop  out  1  replay_req ignored (cooldown)
  tmo_err  out  1  drain timeout pulse

Function
REQ-005 SHALL update out_cnt: +1 on issue_valid&~full, -1 on retire_valid&~empty, unchanged on both or neither.
REQ-006 SHALL ignore issue_valid when out_cnt==max and retire_valid when out_cnt==0 (saturate, no wrap).
REQ-007 SHALL drive issue_ready=1 iff out_cnt!=max, combinationally.
REQ-008 SHALL implement FSM states IDLE, DRAIN, COOL.
REQ-009 IDLE: replay_req & (out_cnt!=0 | ~sb_empty) SHALL assert stall_set same cycle, go to DRAIN; replay_req otherwise SHALL have no effect.
REQ-010 DRAIN: timeout counter SHALL clear on entry and increment each DRAIN cycle.
REQ-011 DRAIN: out_cnt==0 & sb_empty SHALL assert stall_clr same cycle, go to COOL.
REQ-012 DRAIN: when timeout counter==TMO_CYC-1 and not drained, SHALL pulse tmo_err and stall_clr one cycle, go to COOL.
REQ-013 COOL: SHALL remain GAP_CYC cycles then go to IDLE; replay_req in COOL SHALL pulse replay_drop same cycle, no stall_set.
REQ-014 replay_req in DRAIN SHALL have no effect (no stall_set, no replay_drop).
REQ-015 stall SHALL rise the cycle after stall_set, fall the cycle after stall_clr; clr takes priority over set.
REQ-016 flush SHALL, same cycle, assert stall_clr if stall==1; next cycle out_cnt=0, FSM=IDLE, timeout counter=0.
REQ-017 flush SHALL override simultaneous issue_valid, retire_valid, replay_req, suppress stall_set and tmo_err.
REQ-018 stall_set, stall_clr, replay_drop, tmo_err SHALL be single-cycle pulses, never stall_set and stall_clr together.

Reset
REQ-019 On reset_n low SHALL force FSM=IDLE, out_cnt=0, timeout/cooldown counters=0, stall=0, pulses=0, issue_ready=1.
REQ-020 Reset mid-DRAIN SHALL abandon drain without stall_clr or tmo_err.

Structure
REQ-021 FSM state encoding SHALL be a shared-package typedef; CNT_W/TMO_CYC/GAP_CYC defaults SHALL be package constants.
REQ-022 stall SHALL be produced by one nds_flag_setclr instance (SET_OVER_CLR=0, RESET_VALUE=0, USE_EN_PIN=0, en tied 1).
REQ-023 All state SHALL be clk-rising, reset_n-async flops; no latches.

Verification
REQ-024 Issue 3 (out_cnt=3), replay_req -> stall_set cycle N, stall=1 at N+1; retire 3 with sb_empty=1 -> stall_clr on cycle out_cnt reaches 0, stall=0 next cycle.
REQ-025 out_cnt=0, sb_empty=1, replay_req -> no stall_set, FSM stays IDLE.
REQ-026 Issue 15 (CNT_W=4) -> issue_ready=0, 16th issue ignored, out_cnt=15; issue+retire same cycle -> 15 kept.
REQ-027 DRAIN with out_cnt=1 held, TMO_CYC=64 -> tmo_err and stall_clr at 64th DRAIN cycle, COOL 2 cycles, replay_req in COOL -> replay_drop=1.
REQ-028 DRAIN, flush with issue_valid and replay_req -> stall_clr=1, next cycle out_cnt=0, IDLE, stall=0.
REQ-029 reset_n low mid-DRAIN (out_cnt=5) -> all outputs reset values immediately, no pulses.
